// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM.
// Moore decode of state into datapath control strobes.
module multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       ext_op,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e state_q, state_d;
  logic   sw_q, sw_d;
  logic   bne_q, bne_d;

  logic pc_write;
  logic br_take;
  logic ir_write_c;
  logic mem_write_c;
  logic reg_write_c;
  logic illegal_c;

  logic op_r, op_mem, op_br, op_imm, op_j;

  // Opcode classes used by the DECODE dispatch
  always_comb begin
    op_r   = (opcode == OP_R);
    op_mem = (opcode == OP_LW) || (opcode == OP_SW);
    op_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    op_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI)
          || (opcode == OP_ORI);
    op_j   = (opcode == OP_J);
  end

  // State register plus lw/sw and beq/bne flags captured in DECODE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      sw_q    <= 1'b0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      bne_q   <= bne_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d     = S_FETCH;
    sw_d        = sw_q;
    bne_d       = bne_q;
    pc_write    = 1'b0;
    br_take     = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    ext_op      = 1'b0;
    illegal_c   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write_c = 1'b1;
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        sw_d      = (opcode == OP_SW);
        bne_d     = (opcode == OP_BNE);
        unique case (1'b1)
          op_r:    state_d = S_RTEXEC;
          op_mem:  state_d = S_MEMADR;
          op_br:   state_d = S_BRANCH;
          op_imm:  state_d = S_IMMEXEC;
          op_j:    state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        state_d   = sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        iord        = 1'b1;
      end
      S_RTEXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RTWB;
      end
      S_RTWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        br_take   = zero ^ bne_q;
      end
      S_IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ADDI) begin
          ext_op = 1'b1;
          alu_op = 2'b00;
        end else begin
          ext_op = 1'b0;
          alu_op = 2'b11;
        end
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write_c = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Side-effecting strobes are suppressed while reset is held
  assign pc_en     = rst_n & (pc_write | br_take);
  assign ir_write  = rst_n & ir_write_c;
  assign mem_write = rst_n & mem_write_c;
  assign reg_write = rst_n & reg_write_c;
  assign illegal   = rst_n & illegal_c;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control.
// Per-instruction expected control words vs two DUTs.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_op;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    int          len;
    logic [23:0] seq;
    logic        pce_last;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst_t_n;
  logic [5:0] opcode;
  logic       zero;

  logic       pc_en0, iord0, mem_read0, mem_write0, ir_write0;
  logic       mem_to_reg0, reg_dst0, reg_write0, alu_src_a0;
  logic [1:0] alu_src_b0, alu_op0, pc_src0;
  logic       ext_op0, illegal0;
  logic [3:0] state0;

  logic       pc_en1, iord1, mem_read1, mem_write1, ir_write1;
  logic       mem_to_reg1, reg_dst1, reg_write1, alu_src_a1;
  logic [1:0] alu_src_b1, alu_op1, pc_src1;
  logic       ext_op1, illegal1;
  logic [3:0] state1;

  ctl_t got0, got1;

  int errs = 0;
  int checks = 0;
  ctl_t expq[$];

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .pc_en(pc_en0), .iord(iord0), .mem_read(mem_read0),
    .mem_write(mem_write0), .ir_write(ir_write0),
    .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0),
    .reg_write(reg_write0), .alu_src_a(alu_src_a0),
    .alu_src_b(alu_src_b0), .alu_op(alu_op0), .pc_src(pc_src0),
    .ext_op(ext_op0), .state(state0), .illegal(illegal0)
  );

  multicycle_control #(.ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .rst_n(rst_t_n), .opcode(opcode), .zero(zero),
    .pc_en(pc_en1), .iord(iord1), .mem_read(mem_read1),
    .mem_write(mem_write1), .ir_write(ir_write1),
    .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1),
    .reg_write(reg_write1), .alu_src_a(alu_src_a1),
    .alu_src_b(alu_src_b1), .alu_op(alu_op1), .pc_src(pc_src1),
    .ext_op(ext_op1), .state(state1), .illegal(illegal1)
  );

  assign got0 = {state0, pc_en0, iord0, mem_read0, mem_write0,
                 ir_write0, mem_to_reg0, reg_dst0, reg_write0,
                 alu_src_a0, alu_src_b0, alu_op0, pc_src0,
                 ext_op0, illegal0};
  assign got1 = {state1, pc_en1, iord1, mem_read1, mem_write1,
                 ir_write1, mem_to_reg1, reg_dst1, reg_write1,
                 alu_src_a1, alu_src_b1, alu_op1, pc_src1,
                 ext_op1, illegal1};

  function automatic ctl_t blank(input logic [3:0] s);
    ctl_t c;
    c = '0;
    c.st = s;
    return c;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                      OP_ADDI, OP_ANDI, OP_ORI, OP_J};
  endfunction

  // Cycle-by-cycle control words for one instruction
  function automatic void build(input logic [5:0] op,
                                input logic z);
    ctl_t c;
    c = blank(4'd0);
    c.mem_read = 1'b1; c.ir_write = 1'b1;
    c.alu_src_b = 2'b01; c.pc_en = 1'b1;
    expq.push_back(c);
    c = blank(4'd1);
    c.alu_src_b = 2'b11; c.ext_op = 1'b1;
    c.illegal = !legal(op);
    expq.push_back(c);
    if (op == OP_LW || op == OP_SW) begin
      c = blank(4'd2);
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_op = 1'b1;
      expq.push_back(c);
      if (op == OP_LW) begin
        c = blank(4'd3);
        c.mem_read = 1'b1; c.iord = 1'b1;
        expq.push_back(c);
        c = blank(4'd4);
        c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
        expq.push_back(c);
      end else begin
        c = blank(4'd5);
        c.mem_write = 1'b1; c.iord = 1'b1;
        expq.push_back(c);
      end
    end else if (op == OP_R) begin
      c = blank(4'd6);
      c.alu_src_a = 1'b1; c.alu_op = 2'b10;
      expq.push_back(c);
      c = blank(4'd7);
      c.reg_write = 1'b1; c.reg_dst = 1'b1;
      expq.push_back(c);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      c = blank(4'd8);
      c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01;
      c.pc_en = (op == OP_BNE) ? !z : z;
      expq.push_back(c);
    end else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) begin
      c = blank(4'd9);
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      c.ext_op = (op == OP_ADDI);
      c.alu_op = (op == OP_ADDI) ? 2'b00 : 2'b11;
      expq.push_back(c);
      c = blank(4'd10);
      c.reg_write = 1'b1;
      expq.push_back(c);
    end else if (op == OP_J) begin
      c = blank(4'd11);
      c.pc_src = 2'b10; c.pc_en = 1'b1;
      expq.push_back(c);
    end
  endfunction

  task automatic cmp(input string name, input ctl_t g,
                     input ctl_t e);
    checks++;
    if (g !== e) begin
      errs++;
      $display("FAIL %s: got st=%0d ctl=%h, exp st=%0d ctl=%h",
               name, g.st, g, e.st, e);
    end
  endtask

  task automatic chk(input string name, input int g, input int e);
    checks++;
    if (g != e) begin
      errs++;
      $display("FAIL %s: got=%0d exp=%0d", name, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction, check every cycle, report its shape
  task automatic run_instr(input logic [5:0] op, input logic z,
                           output int ncyc,
                           output logic [23:0] seq,
                           output logic pce_last);
    ctl_t e;
    expq.delete();
    build(op, z);
    ncyc = 0;
    seq = '0;
    pce_last = 1'b0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.st inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11})
        opcode = 6'($urandom);
      else
        opcode = op;
      zero = (e.st == 4'd8) ? z : 1'($urandom);
      @(negedge clk);
      cmp($sformatf("op%02h_st%0d", op, e.st), got0, e);
      if (ncyc < 6) seq[4*ncyc +: 4] = got0.st;
      pce_last = got0.pc_en;
      ncyc++;
      tick();
    end
  endtask

  vec_t tbl[12];
  ctl_t em;
  int n, total;
  logic [23:0] sq;
  logic pl;
  logic [5:0] rop;
  logic [5:0] legal_ops[9];

  initial begin
    tbl[0]  = '{OP_LW,   1'b0, 5, 24'h043210, 1'b0};
    tbl[1]  = '{OP_SW,   1'b1, 4, 24'h005210, 1'b0};
    tbl[2]  = '{OP_R,    1'b0, 4, 24'h007610, 1'b0};
    tbl[3]  = '{OP_ADDI, 1'b0, 4, 24'h00A910, 1'b0};
    tbl[4]  = '{OP_ANDI, 1'b1, 4, 24'h00A910, 1'b0};
    tbl[5]  = '{OP_ORI,  1'b0, 4, 24'h00A910, 1'b0};
    tbl[6]  = '{OP_BEQ,  1'b1, 3, 24'h000810, 1'b1};
    tbl[7]  = '{OP_BEQ,  1'b0, 3, 24'h000810, 1'b0};
    tbl[8]  = '{OP_BNE,  1'b1, 3, 24'h000810, 1'b0};
    tbl[9]  = '{OP_BNE,  1'b0, 3, 24'h000810, 1'b1};
    tbl[10] = '{OP_J,    1'b0, 3, 24'h000B10, 1'b1};
    tbl[11] = '{6'h3F,   1'b0, 2, 24'h000010, 1'b0};
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                  OP_ADDI, OP_ANDI, OP_ORI, OP_J};

    rst_n = 1'b0;
    rst_t_n = 1'b0;
    opcode = OP_LW;
    zero = 1'b0;
    tick();
    tick();
    em = blank(4'd0);
    em.mem_read = 1'b1;
    em.alu_src_b = 2'b01;
    @(negedge clk);
    cmp("reset_state", got0, em);
    cmp("reset_state_trap", got1, em);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, tbl[i].z, n, sq, pl);
      chk($sformatf("vec%0d_len", i), n, tbl[i].len);
      chk($sformatf("vec%0d_seq", i), int'(sq), int'(tbl[i].seq));
      chk($sformatf("vec%0d_pce", i), int'(pl), int'(tbl[i].pce_last));
    end

    total = 0;
    run_instr(OP_J, 1'b0, n, sq, pl);
    total += n;
    run_instr(OP_ADDI, 1'b0, n, sq, pl);
    total += n;
    run_instr(OP_R, 1'b0, n, sq, pl);
    total += n;
    chk("b2b_cycles", total, 11);

    expq.delete();
    build(OP_SW, 1'b0);
    for (int i = 0; i < 3; i++) begin
      em = expq.pop_front();
      opcode = OP_SW;
      @(negedge clk);
      cmp($sformatf("swrst_st%0d", em.st), got0, em);
      tick();
    end
    em = expq.pop_front();
    rst_n = 1'b0;
    em.mem_write = 1'b0;
    @(negedge clk);
    cmp("swrst_memwr", got0, em);
    tick();
    em = blank(4'd0);
    em.mem_read = 1'b1;
    em.alu_src_b = 2'b01;
    @(negedge clk);
    cmp("swrst_after", got0, em);
    tick();
    rst_n = 1'b1;
    run_instr(OP_R, 1'b0, n, sq, pl);
    chk("swrst_next_len", n, 4);

    for (int k = 0; k < 60; k++) begin
      int idx;
      idx = int'($urandom_range(0, 9));
      if (idx < 9) begin
        rop = legal_ops[idx];
      end else begin
        rop = 6'h3F;
        for (int t = 0; t < 100; t++) begin
          rop = 6'($urandom);
          if (!legal(rop)) break;
        end
        if (legal(rop)) rop = 6'h3F;
      end
      run_instr(rop, 1'($urandom), n, sq, pl);
    end

    opcode = 6'h3F;
    rst_t_n = 1'b1;
    em = blank(4'd0);
    em.mem_read = 1'b1; em.ir_write = 1'b1;
    em.alu_src_b = 2'b01; em.pc_en = 1'b1;
    @(negedge clk);
    cmp("trap_fetch", got1, em);
    tick();
    em = blank(4'd1);
    em.alu_src_b = 2'b11; em.ext_op = 1'b1; em.illegal = 1'b1;
    @(negedge clk);
    cmp("trap_decode", got1, em);
    tick();
    for (int i = 0; i < 10; i++) begin
      opcode = 6'($urandom);
      zero = 1'($urandom);
      @(negedge clk);
      cmp($sformatf("trap_halt%0d", i), got1, blank(4'd15));
      tick();
    end
    rst_t_n = 1'b0;
    @(negedge clk);
    cmp("trap_halt_rst", got1, blank(4'd15));
    tick();
    em = blank(4'd0);
    em.mem_read = 1'b1;
    em.alu_src_b = 2'b01;
    @(negedge clk);
    cmp("trap_after_rst", got1, em);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Configures the immediate sign extender through `ext_op` (1 = sign-extend, 0 = zero-extend) and selects the extended or shifted immediate via `alu_src_b`.
- Sits between the instruction register (opcode field) and the datapath muxes, register file, memory and PC.

Parameters:
- ILLEGAL_TRAP, 0, 0 = undefined opcode pulses `illegal` and returns to FETCH; 1 = enter HALT and stay there until reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]; stable outside FETCH
- zero  in  1  ALU zero flag
- pc_en  out  1  PC load enable = pc_write | (BRANCH & (zero ^ is_bne))
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A reg
- alu_src_b  out  2  ALU B: 00 = B reg, 01 = const 4, 10 = ext(imm), 11 = ext(imm)<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct decode, 11 = opcode decode (logic imm)
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ext_op  out  1  extender mode: 1 = sign-extend, 0 = zero-extend
- state  out  4  current state, for debug
- illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- State register is 4 bits.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11, HALT=15.
- Reset:
  - At the clk edge with rst_n=0, state <= FETCH.
  - While rst_n=0, `pc_en`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0 combinationally, including when reset is asserted mid-instruction.
  - After release, the first cycle is FETCH with its normal outputs.
- Outputs are a pure decode of `state` (plus `opcode` in DECODE/IMMEXEC and `zero` in BRANCH). Every output not listed for a state is 0.
- FETCH:
  - mem_read=1, ir_write=1, alu_src_b=01, pc_write=1.
  - Next state is DECODE.
- DECODE:
  - alu_src_b=11, ext_op=1 (precomputes the branch target).
  - Next state by opcode:
    - 000000 -> RTEXEC
    - 100011 (lw), 101011 (sw) -> MEMADR
    - 000100 (beq), 000101 (bne) -> BRANCH
    - 001000 (addi), 001100 (andi), 001101 (ori) -> IMMEXEC
    - 000010 (j) -> JUMP
    - any other opcode: illegal=1, then FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1)
- MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Next is MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEMWR: mem_write=1, iord=1. Next is FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next is RTWB.
- RTWB: reg_write=1, reg_dst=1. Next is FETCH.
- BRANCH:
  - alu_src_a=1, alu_op=01, pc_src=01.
  - pc_en = zero for beq, ~zero for bne.
  - Next is FETCH.
- IMMEXEC:
  - alu_src_a=1, alu_src_b=10.
  - addi: ext_op=1, alu_op=00. andi/ori: ext_op=0, alu_op=11.
  - Next is IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- JUMP: pc_src=10, pc_write=1. Next is FETCH.
- HALT: all enables 0; stays in HALT until rst_n=0.
- Unused encodings (12–14) go to FETCH on the next edge with no enables asserted.
- Cycle counts per instruction: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3.
- `opcode` is sampled only in DECODE and IMMEXEC; changes in other states have no effect.

Test Plan:
- Reset, then opcode=100011 (lw) -> state sequence 0,1,2,3,4,0. MEMADR shows ext_op=1, alu_src_b=10. MEMWB shows reg_write=1, mem_to_reg=1.
- opcode=001100 (andi) -> IMMEXEC shows ext_op=0, alu_op=11. IMMWB shows reg_write=1, reg_dst=0. Total 4 cycles.
- opcode=000100 (beq): zero=1 -> pc_en=1, pc_src=01 in BRANCH. zero=0 -> pc_en=0. For opcode=000101 (bne) the results are inverted.
- opcode=111111 with ILLEGAL_TRAP=0 -> illegal=1 for one cycle in DECODE, then FETCH. With ILLEGAL_TRAP=1 -> state=15 held for 10 cycles until rst_n=0.
- sw, with rst_n driven low during MEMWR -> mem_write=0 in that same cycle, state=0 after the edge, and no write strobe is seen.
- Back-to-back j, addi, R-type -> JUMP asserts pc_src=10 and pc_en=1. Total 3+4+4 = 11 cycles with no idle cycles between instructions.
